// File: rtl/fc_error_gen_pkg.sv
// Shared constants, FSM encodings and sign-magnitude arithmetic helpers for fc_error_gen.
// Latency: n/a (package, combinational functions only).
// Backpressure: n/a.
package fc_error_gen_pkg;

    // 1.0 in the fc word format: [31] sign, [30:15] integer, [14:0] fraction.
    localparam logic [31:0] ONE        = 32'h0000_8000;
    localparam logic [30:0] SM_MAX_MAG = 31'h7FFF_FFFF;

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_LABEL   = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;

    // A zero magnitude counts as non-negative, so -0 and +0 compare equal.
    function automatic logic sm_is_neg(input logic [31:0] a);
        return a[31] && (a[30:0] != 31'd0);
    endfunction

    // Strict a > b on sign-magnitude words.
    function automatic logic sm_gt(input logic [31:0] a, input logic [31:0] b);
        logic an;
        logic bn;
        an = sm_is_neg(a);
        bn = sm_is_neg(b);
        if (an != bn)
            return !an;
        else if (!an)
            return a[30:0] > b[30:0];
        else
            return a[30:0] < b[30:0];
    endfunction

    // Saturating sign-magnitude add; a zero result is always +0.
    function automatic logic [31:0] sm_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] sum;
        logic [30:0] mag;
        logic        sgn;
        sum = 32'd0;
        if (a[31] == b[31]) begin
            sum = {1'b0, a[30:0]} + {1'b0, b[30:0]};
            mag = sum[31] ? SM_MAX_MAG : sum[30:0];
            sgn = a[31];
        end else if (a[30:0] >= b[30:0]) begin
            mag = a[30:0] - b[30:0];
            sgn = a[31];
        end else begin
            mag = b[30:0] - a[30:0];
            sgn = b[31];
        end
        if (mag == 31'd0)
            sgn = 1'b0;
        return {sgn, mag};
    endfunction

    function automatic logic [31:0] sm_sub(input logic [31:0] a, input logic [31:0] b);
        return sm_add(a, {~b[31], b[30:0]});
    endfunction

endpackage

// File: rtl/fc_argmax_tracker.sv
// Running argmax over sign-magnitude values; ports: clk/rst, clr_i, upd_i + val_i/idx_i, nxt_idx_o.
// Latency: nxt_idx_o is combinational and already includes the value offered this cycle.
// Backpressure: none; the caller only asserts upd_i on accepted words.
module fc_argmax_tracker
    import fc_error_gen_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             upd_i,
    input  logic [31:0]      val_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [IDX_W-1:0] nxt_idx_o
);

    logic             have_q;
    logic [31:0]      val_q;
    logic [IDX_W-1:0] idx_q;
    logic             take;

    // The first value of an image always wins; after that only a strictly
    // larger value replaces the holder, so ties keep the earlier index.
    assign take      = upd_i && (!have_q || sm_gt(val_i, val_q));
    assign nxt_idx_o = take ? idx_i : idx_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            have_q <= 1'b0;
            val_q  <= 32'd0;
            idx_q  <= '0;
        end else if (take) begin
            have_q <= 1'b1;
            val_q  <= val_i;
            idx_q  <= idx_i;
        end
    end

endmodule

// File: rtl/fc_error_gen.sv
// Collects one image of fc outputs, latches argmax prediction, streams e[k]=y[k]-onehot(label)[k] back.
// Latency: first error word 1 cycle after last input accepted (or after a late label strobe).
// Backpressure: in_rdy low outside collection; out_valid holds data/idx stable until out_rdy.
module fc_error_gen
    import fc_error_gen_pkg::*;
#(
    parameter int N_OUT = 10,
    parameter int IDX_W = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] label,
    input  logic             label_valid,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic [IDX_W-1:0] in_idx,
    output logic             in_rdy,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_rdy,
    output logic [IDX_W-1:0] pred,
    output logic             pred_valid,
    output logic             correct,
    output logic [CNT_W-1:0] correct_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);
    localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(N_OUT);

    logic [1:0]       state_q;
    logic [31:0]      y_q [N_OUT];
    logic [IDX_W-1:0] label_nxt_q;
    logic             label_have_q;
    logic [IDX_W-1:0] label_cur_q;
    logic             out_valid_q;
    logic [31:0]      out_data_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [IDX_W-1:0] pred_q;
    logic             pred_valid_q;
    logic             correct_q;
    logic [CNT_W-1:0] correct_cnt_q;

    logic             acc;
    logic             acc_last;
    logic             emit_go;
    logic [IDX_W-1:0] arg_nxt;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] lbl_new;
    logic [IDX_W-1:0] emit_lbl;
    logic [31:0]      y_sel;
    logic [31:0]      err_d;
    logic             hit;

    assign in_rdy      = (state_q == S_COLLECT);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_idx     = out_idx_q;
    assign pred        = pred_q;
    assign pred_valid  = pred_valid_q;
    assign correct     = correct_q;
    assign correct_cnt = correct_cnt_q;

    // Out-of-range indices are dropped: neither stored nor tracked.
    assign acc      = in_valid && in_rdy && (in_idx < NUM_IDX);
    assign acc_last = acc && (in_idx == LAST_IDX);
    assign hit      = (pred_q == label_cur_q);

    // A label strobe in the same cycle as the last input counts as present.
    always_comb begin
        lbl_new = label_nxt_q;
        emit_go = 1'b0;
        if (state_q == S_COLLECT) begin
            lbl_new = label_valid ? label : label_nxt_q;
            emit_go = acc_last && (label_have_q || label_valid);
        end else if (state_q == S_LABEL) begin
            lbl_new = label;
            emit_go = label_valid;
        end
    end

    // The next error word is computed one step ahead so it can be registered:
    // index 0 when emission starts, k+1 while emitting.
    always_comb begin
        sel_idx  = (state_q == S_EMIT) ? out_idx_q + 1'b1 : '0;
        emit_lbl = (state_q == S_EMIT) ? label_cur_q : lbl_new;
        y_sel    = 32'd0;
        for (int i = 0; i < N_OUT; i++) begin
            if (sel_idx == IDX_W'(i))
                y_sel = (acc && in_idx == IDX_W'(i)) ? in_data : y_q[i];
        end
        err_d = (sel_idx == emit_lbl) ? sm_sub(y_sel, ONE) : y_sel;
    end

    fc_argmax_tracker #(
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (acc_last),
        .upd_i     (acc),
        .val_i     (in_data),
        .idx_i     (in_idx),
        .nxt_idx_o (arg_nxt)
    );

    // Output values are not reset; a reset mid-stream simply drops the image.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_OUT; i++) begin
            if (acc && in_idx == IDX_W'(i))
                y_q[i] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_COLLECT;
            label_nxt_q   <= '0;
            label_have_q  <= 1'b0;
            label_cur_q   <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= 32'd0;
            out_idx_q     <= '0;
            pred_q        <= '0;
            pred_valid_q  <= 1'b0;
            correct_q     <= 1'b0;
            correct_cnt_q <= '0;
        end else begin
            pred_valid_q <= 1'b0;
            if (label_valid) begin
                label_nxt_q  <= label;
                label_have_q <= 1'b1;
            end

            if (acc_last)
                pred_q <= arg_nxt;

            // Entering emission consumes the label, including one strobed this cycle.
            if (emit_go) begin
                state_q      <= S_EMIT;
                label_cur_q  <= lbl_new;
                label_have_q <= 1'b0;
                out_valid_q  <= 1'b1;
                out_idx_q    <= '0;
                out_data_q   <= err_d;
            end else if (acc_last) begin
                state_q <= S_LABEL;
            end else if (state_q == S_EMIT && out_rdy) begin
                if (out_idx_q == LAST_IDX) begin
                    state_q       <= S_COLLECT;
                    out_valid_q   <= 1'b0;
                    pred_valid_q  <= 1'b1;
                    correct_q     <= hit;
                    correct_cnt_q <= correct_cnt_q + CNT_W'(hit);
                end else begin
                    out_idx_q  <= sel_idx;
                    out_data_q <= err_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_error_gen.sv
module tb_fc_error_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  label;
    logic        label_valid;
    logic        in_valid;
    logic [31:0] in_data;
    logic [9:0]  in_idx;
    logic        in_rdy;
    logic        out_valid;
    logic [31:0] out_data;
    logic [9:0]  out_idx;
    logic        out_rdy;
    logic [9:0]  pred;
    logic        pred_valid;
    logic        correct;
    logic [15:0] correct_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] yv [10];
    logic [31:0] ev [10];

    always #5 clk = ~clk;

    fc_error_gen dut (
        .clk         (clk),
        .rst         (rst),
        .label       (label),
        .label_valid (label_valid),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_idx      (in_idx),
        .in_rdy      (in_rdy),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_rdy     (out_rdy),
        .pred        (pred),
        .pred_valid  (pred_valid),
        .correct     (correct),
        .correct_cnt (correct_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_pred", pred, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_correct", correct, 0);
        chk("rst_correct_cnt", correct_cnt, 0);
    endtask

    task automatic give_label(input logic [9:0] l);
        label       = l;
        label_valid = 1'b1;
        @(negedge clk);
        label_valid = 1'b0;
    endtask

    task automatic send_image();
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_idx   = 10'(k);
            in_data  = yv[k];
            chk("in_rdy_collect", in_rdy, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Receive all ten error words; at stall_k hold out_rdy low for 5 cycles.
    task automatic recv_image(input int stall_k);
        logic [31:0] d0;
        logic [9:0]  i0;
        int          w;
        out_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            w = 0;
            while (!out_valid && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!out_valid) begin
                chk("out_valid_timeout", out_valid, 1);
                return;
            end
            chk($sformatf("e_idx_%0d", k), out_idx, k);
            chk($sformatf("e_data_%0d", k), out_data, ev[k]);
            chk("in_rdy_emit", in_rdy, 0);
            if (k == stall_k) begin
                d0      = out_data;
                i0      = out_idx;
                out_rdy = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, ev[k]);
                    chk("stall_idx", out_idx, i0);
                    chk("stall_in_rdy", in_rdy, 0);
                end
                chk("stall_data_vs_first", out_data, d0);
                out_rdy = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_result(input logic [9:0] p, input logic c, input logic [15:0] cnt);
        chk("pred_valid_pulse", pred_valid, 1);
        chk("pred", pred, p);
        chk("correct", correct, c);
        chk("correct_cnt", correct_cnt, cnt);
        chk("done_out_valid", out_valid, 0);
        chk("done_in_rdy", in_rdy, 1);
        @(negedge clk);
        chk("pred_valid_drop", pred_valid, 0);
    endtask

    task automatic copy_y_to_e();
        for (int k = 0; k < 10; k++) ev[k] = yv[k];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; label = '0; label_valid = 1'b0;
        in_valid = 1'b0; in_data = '0; in_idx = '0; out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst = 1'b0;
        @(negedge clk);

        // Image 1: basic, with an out-of-range index that must be ignored.
        give_label(10'd2);
        in_valid = 1'b1; in_idx = 10'd12; in_data = 32'h7FFF_0000;
        chk("in_rdy_oob", in_rdy, 1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) yv[k] = 32'h0;
        yv[0] = 32'h0000_4000; yv[1] = 32'h8000_8000; yv[2] = 32'h0001_0000;
        copy_y_to_e();
        ev[2] = 32'h0000_8000;
        send_image();
        chk("first_out_latency", out_valid, 1);
        recv_image(-1);
        chk_result(10'd2, 1'b1, 16'd1);

        // Image 2: tie between 3 and 7 keeps the lower index.
        give_label(10'd7);
        for (int k = 0; k < 10; k++) yv[k] = 32'h8000_8000;
        yv[3] = 32'h0001_8000; yv[7] = 32'h0001_8000;
        copy_y_to_e();
        ev[7] = 32'h0001_0000;
        send_image();
        recv_image(-1);
        chk_result(10'd3, 1'b0, 16'd1);

        // Image 3: all negative, y[k] = -(k+1).
        give_label(10'd0);
        for (int k = 0; k < 10; k++) yv[k] = 32'h8000_0000 | (32'(k + 1) << 15);
        copy_y_to_e();
        ev[0] = 32'h8001_0000;
        send_image();
        recv_image(-1);
        chk_result(10'd0, 1'b0 | 1'b1, 16'd2);

        // Image 4: -0 at idx 0 ties +0 at idx 1; label on the +0 gives -1.0.
        give_label(10'd1);
        for (int k = 0; k < 10; k++) yv[k] = 32'h8000_8000;
        yv[0] = 32'h8000_0000; yv[1] = 32'h0000_0000;
        copy_y_to_e();
        ev[1] = 32'h8000_8000;
        send_image();
        recv_image(-1);
        chk_result(10'd0, 1'b0, 16'd2);

        // Image 5: y[k]=k*0.5, label 2 (y=1.0 -> +0), stall at k=4.
        give_label(10'd2);
        for (int k = 0; k < 10; k++) yv[k] = 32'(k) * 32'h0000_4000;
        copy_y_to_e();
        ev[2] = 32'h0000_0000;
        send_image();
        recv_image(4);
        chk_result(10'd9, 1'b0, 16'd2);

        // Image 6: no label before the last input -> wait in S_LABEL.
        for (int k = 0; k < 10; k++) yv[k] = 32'h0;
        yv[8] = 32'h0000_8000;
        copy_y_to_e();
        ev[8] = 32'h0000_0000;
        send_image();
        for (int s = 0; s < 3; s++) begin
            chk("label_wait_out_valid", out_valid, 0);
            chk("label_wait_in_rdy", in_rdy, 0);
            @(negedge clk);
        end
        give_label(10'd8);
        chk("emit_after_label", out_valid, 1);
        recv_image(-1);
        chk_result(10'd8, 1'b1, 16'd3);

        // Image 7: reset in the middle of emission.
        give_label(10'd1);
        for (int k = 0; k < 10; k++) yv[k] = 32'h0000_2000;
        send_image();
        out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_emit_idx", out_idx, 3);
        rst = 1'b1; out_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state();
        @(negedge clk);

        // Image 8: clean image after reset.
        give_label(10'd3);
        for (int k = 0; k < 10; k++) yv[k] = 32'h0;
        yv[3] = 32'h0000_4000;
        copy_y_to_e();
        ev[3] = 32'h8000_4000;
        send_image();
        recv_image(-1);
        chk_result(10'd3, 1'b1, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
